// File: rtl/div_seq_if.sv
// Handshake and data bundle between the EX stage and the divide sequencer.
//
// Handshake: start_i is a level request. The EX stage raises it with the
// operands and holds it until it sees ready_o. The request is taken only in
// a cycle where the sequencer is idle and annul_i is low. Operands are
// captured in that cycle; later changes are ignored. ready_o/result_o then
// stay valid for as long as start_i stays high. Dropping start_i, or raising
// annul_i, releases the result. A new request needs start_i low for at least
// one cycle first. annul_i cancels any pending or in-flight divide.
// stall_req_o asks pipeline control to hold EX while a divide is in flight.
interface div_seq_if #(
  parameter int DW = 32
);
  logic            start_i;
  logic            annul_i;
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;
  logic            stall_req_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU. It produces one quotient
// bit per cycle from a single DW+1-bit trial subtractor. It returns
// {remainder, quotient} and holds a stall request while a divide is running.
// Optional build macro: DIV_EARLY_OUT_EN. When it is defined, the sequencer
// finishes at once if |dividend| < |divisor|.
// The bus interface must be instantiated with the same DW as this module.
module div_seq #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DW-1:0]     dvd_q;      // dividend magnitude, shifted out MSB first
  logic [DW-1:0]     dvs_q;      // divisor magnitude
  logic [DW-1:0]     rem_q;      // partial remainder
  logic [DW-1:0]     quo_q;      // quotient bits collected so far
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [2*DW-1:0]   result_q;
  logic              ready_q;

  logic              accept;
  logic              div_zero;
  logic              early_out;
  logic              last_iter;
  logic              stall;
  logic [DW-1:0]     abs1, abs2;
  logic [DW:0]       shifted, trial;
  logic              bit_ok;
  logic [DW-1:0]     rem_nxt, quo_nxt, rem_fin, quo_fin;

  // Take operand magnitudes, evaluate one restoring step, and form the signed result.
  always_comb begin
    accept   = bus.start_i & ~bus.annul_i;
    div_zero = (bus.opdata2_i == '0);
    abs1 = (bus.signed_div_i & bus.opdata1_i[DW-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs2 = (bus.signed_div_i & bus.opdata2_i[DW-1]) ? -bus.opdata2_i : bus.opdata2_i;
    shifted = {rem_q, dvd_q[DW-1]};
    trial   = shifted - {1'b0, dvs_q};
    bit_ok  = ~trial[DW];
    rem_nxt = bit_ok ? trial[DW-1:0] : shifted[DW-1:0];
    quo_nxt = {quo_q[DW-2:0], bit_ok};
    rem_fin = neg_rem_q ? -rem_nxt : rem_nxt;
    quo_fin = neg_quo_q ? -quo_nxt : quo_nxt;
    last_iter = (cnt_q == CNT_W'(DW - 1));
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (abs1 < abs2);
`else
  assign early_out = 1'b0;
`endif

  // Choose the next sequencer state and raise the stall request.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (div_zero)       state_d = S_ZERO;
          else if (early_out) state_d = S_END;
          else                state_d = S_ON;
        end
      end
      S_ZERO: begin
        stall   = ~bus.annul_i;
        state_d = bus.annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        stall = ~bus.annul_i;
        if (bus.annul_i)    state_d = S_IDLE;
        else if (last_iter) state_d = S_END;
      end
      S_END: begin
        if (!bus.start_i || bus.annul_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Hold the sequencer state.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture operands, run one iteration per cycle, and publish or release the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= (state_d == S_END);
      case (state_q)
        S_IDLE: begin
          if (accept && !div_zero) begin
            dvd_q     <= abs1;
            dvs_q     <= abs2;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= bus.signed_div_i & (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
            neg_rem_q <= bus.signed_div_i & bus.opdata1_i[DW-1];
            // Early exit: the quotient is 0 and the dividend itself is the remainder.
            if (early_out) result_q <= {bus.opdata1_i, {DW{1'b0}}};
          end
        end
        S_ZERO: result_q <= '0;
        S_ON: begin
          dvd_q <= dvd_q << 1;
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter && !bus.annul_i) result_q <= {rem_fin, quo_fin};
        end
        S_END: begin
          if (state_d == S_IDLE) result_q <= '0;
        end
        default: result_q <= '0;
      endcase
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.stall_req_o = stall;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq. An arithmetic model gives the expected result
// and completion latency of each divide. A per-cycle compare process checks
// ready_o, stall_req_o and result_o. Literal values pin the model.
module tb_div_seq;
  localparam int DW = 32;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  div_seq_if #(.DW(DW)) bus ();

  div_seq #(.DW(DW), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic            chk_en     = 1'b0;
  logic            exp_ready  = 1'b0;
  logic            exp_stall  = 1'b0;
  logic [2*DW-1:0] exp_result = '0;
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: plain signed/unsigned division with truncation toward zero
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin sa = $signed(a); sb = $signed(b); end
    else begin sa = {32'd0, a}; sb = {32'd0, b}; end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic longint mag(input logic sg, input logic [31:0] v);
    longint x;
    if (sg) x = $signed(v); else x = {32'd0, v};
    return (x < 0) ? -x : x;
  endfunction

  // cycles from the acceptance cycle to the first cycle with ready_o high
  function automatic int latency(input logic sg, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(sg, a) < mag(sg, b)) return 1;
`endif
    return DW + 1;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o", {63'd0, bus.ready_o}, {63'd0, exp_ready});
      check("stall_req_o", {63'd0, bus.stall_req_o}, {63'd0, exp_stall});
      check("result_o", bus.result_o, exp_result);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // driver: one divide; abort_at > 0 aborts at that cycle offset (annul or reset)
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input int hold, input int abort_at,
                        input bit abort_rst);
    logic [63:0] exp_r;
    int          lat;
    exp_r = model(sg, a, b);
    lat   = latency(sg, a, b);
    check("model_vs_literal", exp_r, lit);
    exp_q.push_back(exp_r);
    bus.start_i = 1'b1; bus.annul_i = 1'b0;
    bus.signed_div_i = sg; bus.opdata1_i = a; bus.opdata2_i = b;
    exp_stall = 1'b1; exp_ready = 1'b0; exp_result = '0;
    for (int c = 1; c <= lat + hold; c++) begin
      next_cycle();
      // later operand changes must be ignored
      bus.opdata1_i = $urandom; bus.opdata2_i = $urandom;
      bus.signed_div_i = 1'($urandom_range(0, 1));
      if (c == abort_at) begin
        bus.start_i = 1'b0;
        exp_ready = 1'b0; exp_result = '0;
        if (abort_rst) begin rst = 1'b1; exp_stall = 1'b1; end
        else begin bus.annul_i = 1'b1; exp_stall = 1'b0; end
        next_cycle();
        rst = 1'b0; bus.annul_i = 1'b0;
        exp_stall = 1'b0; exp_ready = 1'b0; exp_result = '0;
        check("state_after_abort", {62'd0, state_dbg}, 64'd0);
        void'(exp_q.pop_front());
        next_cycle();
        return;
      end
      if (c < lat) begin
        exp_stall = 1'b1; exp_ready = 1'b0; exp_result = '0;
      end else begin
        exp_stall = 1'b0; exp_ready = 1'b1; exp_result = exp_q[0];
        if (c == lat) check("result_literal", bus.result_o, lit);
      end
    end
    next_cycle();
    bus.start_i = 1'b0;
    exp_stall = 1'b0; exp_ready = 1'b1; exp_result = exp_q.pop_front();
    next_cycle();
    exp_ready = 1'b0; exp_result = '0; exp_stall = 1'b0;
    check("state_after_release", {62'd0, state_dbg}, 64'd0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    next_cycle();
    chk_en = 1'b1;
    check("reset_state", {62'd0, state_dbg}, 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    do_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 0, 0, 1'b0);
    do_div(1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0, 1'b0);
    do_div(1'b1, 32'd7, -32'sd2, {32'h00000001, 32'hFFFFFFFD}, 0, 0, 1'b0);
    do_div(1'b1, -32'sd100, -32'sd7, {32'hFFFFFFFE, 32'h0000000E}, 1, 0, 1'b0);
    do_div(1'b0, 32'd5, 32'd0, 64'd0, 0, 0, 1'b0);
    do_div(1'b1, -32'sd5, 32'd0, 64'd0, 2, 0, 1'b0);
    do_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 0, 10, 1'b0);
    do_div(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 0, 0, 1'b0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 5, 0, 1'b0);
    do_div(1'b0, 32'd5, 32'd9, {32'h5, 32'h0}, 0, 0, 1'b0);
    do_div(1'b1, -32'sd5, 32'd9, {32'hFFFFFFFB, 32'h0}, 0, 0, 1'b0);
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 0, 0, 1'b0);
    do_div(1'b0, 32'd12345, 32'd10, {32'd5, 32'd1234}, 0, 6, 1'b1);

    // start together with annul in IDLE: nothing is accepted
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
    exp_stall = 1'b0; exp_ready = 1'b0; exp_result = '0;
    next_cycle();
    check("start_annul_idle", {62'd0, state_dbg}, 64'd0);
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    next_cycle();

    do_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 0, 0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
